// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round scheduler.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    HOLD  = 3'd4
  } aes_state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned AES192_ROUNDS = 12;
  localparam int unsigned AES256_ROUNDS = 14;

endpackage

// File: rtl/aes_rr_arbiter2.sv
// Two-requester round-robin arbiter; req_i[0]/gnt_o[0] is encipher, [1] is decipher.
module aes_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Resets to the decipher port so encipher wins the first tie.
  logic last_q;

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (en_i && (|req_i)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Arbitrates encipher/decipher requests and sequences the shared AES round datapath.
// Optional feature macro: AES_SCHED_ABORT_EN (adds synchronous abort input).
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef AES_SCHED_ABORT_EN
  input  logic       abort,
`endif
  input  logic       enc_valid,
  output logic       enc_ready,
  input  logic       dec_valid,
  output logic       dec_ready,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic       dp_final,
  output logic       dp_mode,
  output logic [3:0] round_num,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LOAD  = LOAD;
  localparam logic [2:0] S_ROUND = ROUND;
  localparam logic [2:0] S_FINAL = FINAL;
  localparam logic [2:0] S_HOLD  = HOLD;

  localparam logic [3:0] NR = 4'(NUM_ROUNDS);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [1:0] gnt;
  logic       in_idle;
  logic       abort_w;
  logic [3:0] cnt_step;
  logic [3:0] load_cnt;
  logic [3:0] fin_cnt;
  logic       mid_ok;
  logic       last_mid;

`ifdef AES_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign in_idle = (state_q == S_IDLE);

  aes_rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({dec_valid, enc_valid}),
    .en_i  (in_idle),
    .gnt_o (gnt)
  );

  assign enc_ready = gnt[0];
  assign dec_ready = gnt[1];

  // Expected count at each fixed point of the block; a mismatch means corruption.
  assign cnt_step = (mode_q == MODE_DEC) ? cnt_q - 4'd1 : cnt_q + 4'd1;
  assign load_cnt = (mode_q == MODE_DEC) ? NR : 4'd0;
  assign fin_cnt  = (mode_q == MODE_DEC) ? 4'd0 : NR;
  assign mid_ok   = (cnt_q != 4'd0) && (cnt_q < NR);
  assign last_mid = (mode_q == MODE_DEC) ? (cnt_q == 4'd1) : (cnt_q == NR - 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          mode_d  = gnt[1] ? MODE_DEC : MODE_ENC;
          cnt_d   = gnt[1] ? NR : 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == load_cnt) begin
          cnt_d   = cnt_step;
          state_d = S_ROUND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUND: begin
        if (!mid_ok) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_step;
          if (last_mid) state_d = S_FINAL;
        end
      end
      S_FINAL: state_d = (cnt_q == fin_cnt) ? S_HOLD : S_IDLE;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_w && !in_idle) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_ENC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign dp_load     = (state_q == S_LOAD)  && (cnt_q == load_cnt);
  assign dp_round_en = (state_q == S_ROUND) && mid_ok;
  assign dp_final    = (state_q == S_FINAL) && (cnt_q == fin_cnt);
  assign out_valid   = (state_q == S_HOLD);
  assign busy        = !in_idle;
  assign dp_mode     = mode_q;
  assign round_num   = cnt_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, a negedge monitor compares.
module tb_aes_round_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
`ifdef AES_SCHED_ABORT_EN
  logic       abort;
`endif
  logic       enc_valid, enc_ready, dec_valid, dec_ready;
  logic       dp_load, dp_round_en, dp_final, dp_mode;
  logic [3:0] round_num;
  logic       out_valid, out_ready, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] val;
    logic [11:0] mask;
    int          dt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  aes_round_scheduler #(.NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_SCHED_ABORT_EN
    .abort       (abort),
`endif
    .enc_valid   (enc_valid),
    .enc_ready   (enc_ready),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dp_load     (dp_load),
    .dp_round_en (dp_round_en),
    .dp_final    (dp_final),
    .dp_mode     (dp_mode),
    .round_num   (round_num),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  // {enc_ready, dec_ready, load, round_en, final, out_valid, busy, mode, round_num[3:0]}
  function automatic logic [11:0] obs();
    return {enc_ready, dec_ready, dp_load, dp_round_en, dp_final, out_valid,
            busy, dp_mode, round_num};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic push_rec(input logic [11:0] val, input logic [11:0] mask, input int dt);
    exp_t e;
    e.val = val; e.mask = mask; e.dt = dt;
    exp_q.push_back(e);
  endtask

  // n_round < 9 models a block cut short; n_hold counts HOLD cycles including the handshake.
  task automatic push_block(input bit dec, input int n_round, input int n_hold, input int gdt);
    logic [11:0] m;
    logic [3:0]  rn;
    m = dec ? 12'h010 : 12'h000;
    push_rec(dec ? 12'h400 : 12'h800, 12'hFE0, gdt);
    push_rec(12'h220 | m | (dec ? 12'd10 : 12'd0), 12'hFFF, 1);
    for (int i = 1; i <= n_round; i++) begin
      rn = dec ? 4'(10 - i) : 4'(i);
      push_rec(12'h120 | m | {8'h00, rn}, 12'hFFF, 1);
    end
    if (n_round == 9) begin
      push_rec(12'h0A0 | m | (dec ? 12'd0 : 12'd10), 12'hFFF, 1);
      for (int h = 0; h < n_hold; h++)
        push_rec(12'h060 | m | (dec ? 12'd0 : 12'd10), 12'hFFF, 1);
    end
  endtask

  int cyc = 0;
  int last_cyc = 0;

  always @(negedge clk) begin
    logic [11:0] o;
    exp_t e;
    cyc++;
    o = obs();
    if (rst_n && (o[11:5] != 7'd0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %03h expected none", o);
      end else begin
        e = exp_q.pop_front();
        chk("cycle_outputs", o & e.mask, e.val & e.mask);
        if (e.dt != 0) chk("cycle_spacing", 12'(cyc - last_cyc), 12'(e.dt));
      end
      last_cyc = cyc;
    end
  end

  task automatic wait_ready(input bit dec);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dec ? dec_ready : enc_ready) begin
        done = 1'b1;
        break;
      end
    end
    chk(dec ? "dec_grant_timeout" : "enc_grant_timeout", {11'd0, done}, 12'd1);
    @(posedge clk);
    #1;
    if (dec) dec_valid = 1'b0;
    else     enc_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", {11'd0, done}, 12'd1);
  endtask

  initial begin
    int  grants;
    bit  seen;
    rst_n = 1'b0;
`ifdef AES_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset_values", obs(), 12'h000);
    #11;
    rst_n = 1'b1;

    // Both ports pending for four blocks: enc, dec, enc, dec back to back.
    push_block(1'b0, 9, 1, 0);
    push_block(1'b1, 9, 1, 1);
    push_block(1'b0, 9, 1, 1);
    push_block(1'b1, 9, 1, 1);
    @(posedge clk);
    #1;
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    grants = 0;
    for (int i = 0; i < 200 && grants < 4; i++) begin
      @(negedge clk);
      if (enc_ready || dec_ready) grants++;
    end
    @(posedge clk);
    #1;
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    chk("alternating_grants", 12'(grants), 12'd4);
    wait_drain();

    // Single encipher then single decipher.
    push_block(1'b0, 9, 1, 0);
    enc_valid = 1'b1;
    wait_ready(1'b0);
    wait_drain();
    push_block(1'b1, 9, 1, 0);
    dec_valid = 1'b1;
    wait_ready(1'b1);
    wait_drain();

    // Backpressure: seven HOLD cycles with out_ready low, decipher waiting.
    out_ready = 1'b0;
    push_block(1'b0, 9, 8, 0);
    enc_valid = 1'b1;
    wait_ready(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("out_valid_timeout", {11'd0, seen}, 12'd1);
    #1;
    dec_valid = 1'b1;
    push_block(1'b1, 9, 1, 1);
    repeat (7) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_ready(1'b1);
    wait_drain();

    // Reset while round_num is 5.
    push_block(1'b0, 5, 0, 0);
    enc_valid = 1'b1;
    wait_ready(1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("round_before_reset", {8'd0, round_num}, 12'd5);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", obs(), 12'h000);
    chk("reset_queue_consumed", 12'(exp_q.size()), 12'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("quiet_after_reset", obs(), 12'h000);

`ifdef AES_SCHED_ABORT_EN
    // Abort encipher at round 4 with decipher pending; decipher is granted next.
    push_block(1'b0, 4, 0, 0);
    push_block(1'b1, 9, 1, 1);
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    wait_ready(1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("round_at_abort", {8'd0, round_num}, 12'd4);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("idle_after_abort", {11'd0, busy}, 12'd0);
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    wait_drain();
`endif

    chk("scoreboard_empty", 12'(exp_q.size()), 12'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Sequencing controller and two-port arbiter for the shared iterative AES round datapath. It accepts block requests from an encipher port and a decipher port, grants one at a time with round-robin fairness, and steps the datapath through load, middle rounds and final round. It drives the round-key index forward for encipher and backward for decipher, then holds the result until the consumer accepts it. It sits between the bus/interface logic and the round datapath plus round-key store, replacing per-direction round counters.

## Interface
- NUM_ROUNDS, 10: total AES rounds. Legal values are 10, 12 and 14.
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enc_valid  in  1  encipher request pending.
- enc_ready  out  1  encipher request accepted this cycle.
- dec_valid  in  1  decipher request pending.
- dec_ready  out  1  decipher request accepted this cycle.
- dp_load  out  1  datapath captures input block and applies initial AddRoundKey.
- dp_round_en  out  1  datapath executes one full middle round.
- dp_final  out  1  datapath executes the final round (no MixColumns).
- dp_mode  out  1  0 = encipher, 1 = decipher; stable from grant until handshake.
- round_num  out  4  round-key index to the key store.
- out_valid  in/out: out  1  result available.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, HOLD.
- IDLE:
  - If any valid is high, grant one request: assert its ready for exactly one cycle, latch dp_mode, go to LOAD.
  - If both are valid, grant the port not granted last. The last-grant register resets to "decipher", so encipher wins the first tie.
  - A ready never asserts outside IDLE, and never asserts for both ports in the same cycle.
- LOAD: dp_load=1 for one cycle.
  - round_num = 0 for encipher, NUM_ROUNDS for decipher.
  - Next state is ROUND.
- ROUND: dp_round_en=1 for NUM_ROUNDS-1 cycles.
  - round_num steps 1..NUM_ROUNDS-1 for encipher.
  - round_num steps NUM_ROUNDS-1..1 for decipher.
  - Next state is FINAL.
- FINAL: dp_final=1 for one cycle.
  - round_num = NUM_ROUNDS for encipher, 0 for decipher.
  - Next state is HOLD.
- HOLD: out_valid=1.
  - round_num holds its FINAL value.
  - On out_valid && out_ready, go to IDLE.
  - A new request can be granted on the cycle after the handshake, not on the handshake cycle itself.
- Output gating: dp_load, dp_round_en and dp_final are mutually exclusive and are 0 in IDLE and HOLD.
- Round counter arithmetic: 4-bit, with no wrap in normal operation.
  - Encipher increments, decipher decrements.
  - Any illegal state or an out-of-range count forces a return to IDLE with all strobes low.
- Reset at any time: all outputs go to reset values immediately and any in-flight block is discarded.
- Reset values: enc_ready=0, dec_ready=0, dp_load=0, dp_round_en=0, dp_final=0, dp_mode=0, round_num=0, out_valid=0, busy=0. FSM resets to IDLE.

## Timing
- Grant cycle: the ready pulse is combinational from valid and state, in IDLE.
- dp_load is registered and asserts on the cycle after the grant.
- Latency from grant edge to first out_valid is NUM_ROUNDS+1 cycles (11 for AES-128).
- Throughput with out_ready tied high: one block per NUM_ROUNDS+3 cycles.
- out_valid stays high and round_num/dp_mode stay stable until out_ready is sampled high.
- Requesters must keep valid asserted until they see ready. Dropping valid before grant is legal, and the request is simply not served.

## Configuration
- AES_SCHED_ABORT_EN defined:
  - Adds input `abort` (1 bit, synchronous).
  - abort=1 in LOAD, ROUND, FINAL or HOLD returns the FSM to IDLE on the next edge.
  - All strobes and out_valid are deasserted, and no result handshake occurs.
  - The last-grant register still records the aborted port.
  - abort in IDLE has no effect and does not block a grant in that cycle.
- Macro undefined: the port does not exist and blocks always run to completion.

## Structure
- Shared package aes_pkg holds:
  - the state enum (IDLE, LOAD, ROUND, FINAL, HOLD);
  - mode constants MODE_ENC=0 and MODE_DEC=1;
  - round-count constants AES128_ROUNDS=10, AES192_ROUNDS=12, AES256_ROUNDS=14.
- One sub-module, aes_rr_arbiter2: two-requester round-robin arbiter with a last-grant register and an advance enable.
- The FSM and round counter live in the top module.

## Test plan
- Reset mid-ROUND: assert rst_n=0 at round_num=5. All outputs go to 0 asynchronously, FSM goes to IDLE, and after release no strobes assert until a new valid.
- Single encipher, NUM_ROUNDS=10, out_ready=1:
  - enc_ready pulses for one cycle;
  - round_num sequence is 0,1..9,10 with dp_load, 9×dp_round_en, dp_final;
  - out_valid appears 11 cycles after grant.
- Single decipher:
  - round_num sequence is 10,9..1,0 and dp_mode=1 throughout;
  - out_valid appears 11 cycles after grant.
- Both valid continuously for 4 blocks: grants alternate enc, dec, enc, dec, and ready is never asserted to both ports in one cycle.
- Backpressure: hold out_ready=0 for 7 cycles in HOLD. out_valid, round_num=10 and dp_mode stay stable, and no grant occurs until the cycle after out_ready=1.
- With AES_SCHED_ABORT_EN: assert abort at round_num=4 of an encipher block with dec_valid=1. The FSM is in IDLE next cycle, no out_valid is produced, and dec is granted next.
